// File: rtl/axis_rr_packet_arbiter_if.sv
// Bundle of the NUM_SRC slave streams and the merged master stream of the arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding logic's view.
interface axis_rr_packet_arbiter_if #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 2
);
   logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
   logic [NUM_SRC-1:0]            s_tvalid;
   logic [NUM_SRC-1:0]            s_tlast;
   logic [NUM_SRC-1:0]            s_tready;
   logic [DATA_WIDTH-1:0]         m_tdata;
   logic                          m_tvalid;
   logic                          m_tlast;
   logic [ID_WIDTH-1:0]           m_tuser;
   logic                          m_tready;

   modport master (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
   );

   modport slave (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast, m_tuser
   );
endinterface

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-Stream sources onto one
// registered master port; the grant is held from the first beat to tlast.
module axis_rr_packet_arbiter #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   axis_rr_packet_arbiter_if.master bus,
   output logic                busy,
   output logic [ID_WIDTH-1:0] grant_id
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e                  state_q, state_d;
   logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
   logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
   logic                    m_tvalid_q, m_tvalid_d;
   logic                    m_tlast_q, m_tlast_d;
   logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
   logic [ID_WIDTH-1:0]     m_tuser_q, m_tuser_d;

   logic                    out_ok;
   logic                    accept;
   logic                    sel_valid;
   logic                    sel_last;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [2*NUM_SRC-1:0]    req_dbl;
   logic [NUM_SRC-1:0]      req_rot;
   logic                    req_found;
   logic [ID_WIDTH-1:0]     req_idx;
   logic [NUM_SRC-1:0]      s_tready;

   assign out_ok = !m_tvalid_q || bus.m_tready;
   assign accept = (state_q == StBusy) && sel_valid && out_ok;

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (grant_id_q == ID_WIDTH'(i)) begin
            sel_valid = bus.s_tvalid[i];
            sel_last  = bus.s_tlast[i];
            sel_data  = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Rotate requests so bit 0 is the port at ptr, then take the first set bit.
   always_comb begin
      req_dbl   = {bus.s_tvalid, bus.s_tvalid} >> ptr_q;
      req_rot   = req_dbl[NUM_SRC-1:0];
      req_found = 1'b0;
      req_idx   = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (!req_found && req_rot[k]) begin
            req_found = 1'b1;
            req_idx   = ID_WIDTH'((32'(ptr_q) + k) % NUM_SRC);
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         s_tready[i] = (state_q == StBusy) && (grant_id_q == ID_WIDTH'(i)) && out_ok;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      m_tvalid_d = m_tvalid_q;
      m_tlast_d  = m_tlast_q;
      m_tdata_d  = m_tdata_q;
      m_tuser_d  = m_tuser_q;

      unique case (state_q)
         StIdle: begin
            if (req_found) begin
               grant_id_d = req_idx;
               state_d    = StBusy;
            end
         end
         StBusy: begin
            if (accept && sel_last) begin
               state_d = StIdle;
               ptr_d   = ID_WIDTH'((32'(grant_id_q) + 1) % NUM_SRC);
            end
         end
         default: state_d = StIdle;
      endcase

      // A load takes priority; otherwise a taken beat empties the output stage.
      if (accept) begin
         m_tvalid_d = 1'b1;
         m_tdata_d  = sel_data;
         m_tlast_d  = sel_last;
         m_tuser_d  = grant_id_q;
      end else if (bus.m_tready) begin
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         grant_id_q <= '0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tdata_q  <= '0;
         m_tuser_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         m_tvalid_q <= m_tvalid_d;
         m_tlast_q  <= m_tlast_d;
         m_tdata_q  <= m_tdata_d;
         m_tuser_q  <= m_tuser_d;
      end
   end

   assign bus.s_tready = s_tready;
   assign bus.m_tvalid = m_tvalid_q;
   assign bus.m_tdata  = m_tdata_q;
   assign bus.m_tlast  = m_tlast_q;
   assign bus.m_tuser  = m_tuser_q;
   assign busy         = (state_q == StBusy);
   assign grant_id     = grant_id_q;

endmodule
